// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with synchronized input and mid-bit sampling
module uart_rx #(
    parameter int BAUD_CYCLES = 2605,
    parameter int HALF_CYCLES = 1302
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVE   = 2'd1,
        STOP_WAIT = 2'd2
    } state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_CYCLES - 1);
    localparam logic [11:0] HALF_LAST = 12'(HALF_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shift_reg;

    logic        start_edge;
    logic        sample_pt;
    logic        half_done;
    logic        frame_start;
    logic        shift_en;
    logic        load_byte;

    // Falling edge on the synchronized line; only acted on while idle.
    assign start_edge = rx_prev & ~rx_sync;

    // The start-bit sample is half a bit in; every later sample is a full bit apart.
    assign sample_pt = (state == RECEIVE) &&
                       (baud_cnt == ((bit_cnt == 4'd0) ? HALF_LAST : BAUD_LAST));

    assign half_done = (state == STOP_WAIT) && (baud_cnt == HALF_LAST);

    // Two-flop synchronizer plus one history flop for edge detection; idle-high on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: false starts and completed frames both return to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = RECEIVE;
                end
            end
            RECEIVE: begin
                if (sample_pt) begin
                    if ((bit_cnt == 4'd0) && rx_sync) begin
                        state_nxt = IDLE;
                    end else if (bit_cnt == 4'd9) begin
                        state_nxt = STOP_WAIT;
                    end
                end
            end
            STOP_WAIT: begin
                if (half_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode: data and stop samples shift in; a good stop bit publishes the byte.
    always_comb begin
        frame_start = 1'b0;
        shift_en    = 1'b0;
        load_byte   = 1'b0;
        case (state)
            IDLE:      frame_start = start_edge;
            RECEIVE:   shift_en    = sample_pt && (bit_cnt != 4'd0);
            STOP_WAIT: load_byte   = half_done && shift_reg[8];
            default: begin
                frame_start = 1'b0;
                shift_en    = 1'b0;
                load_byte   = 1'b0;
            end
        endcase
    end

    // Baud and bit counters; the baud counter restarts at every sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= 12'd0;
            bit_cnt  <= 4'd0;
        end else if (frame_start) begin
            baud_cnt <= 12'd0;
            bit_cnt  <= 4'd0;
        end else if (state == RECEIVE) begin
            if (sample_pt) begin
                baud_cnt <= 12'd0;
                bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + 12'd1;
            end
        end else if (state == STOP_WAIT) begin
            baud_cnt <= half_done ? 12'd0 : baud_cnt + 12'd1;
        end
    end

    // Shift register fills from the MSB so bit 0 lands in [0] and the stop bit in [8].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 9'd0;
        end else if (frame_start) begin
            shift_reg <= 9'd0;
        end else if (shift_en) begin
            shift_reg <= {rx_sync, shift_reg[8:1]};
        end
    end

    // Ready is a level: cleared by the next start edge, set when a good frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy  <= 1'b0;
            rx_data <= 8'h00;
        end else if (frame_start) begin
            rx_rdy  <= 1'b0;
        end else if (load_byte) begin
            rx_rdy  <= 1'b1;
            rx_data <= shift_reg[7:0];
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks for uart_rx
module tb_uart_rx;

    localparam int BAUD = 109;
    localparam int HALF = 54;
    localparam int LAT  = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rx_rdy;
    logic [7:0] rx_data;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_CYCLES(BAUD), .HALF_CYCLES(HALF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_cyc);
        logic [9:0] bits;
        int         early;
        int         rise_at;
        bits    = {stop, b, 1'b0};
        early   = 0;
        rise_at = -1;
        for (int i = 0; i < 10 * BAUD; i++) begin
            @(posedge clk);
            #1;
            if (i == abort_cyc) begin
                rst_n = 1'b0;
                rx    = 1'b1;
                repeat (3) @(negedge clk);
                exp_data = 8'h00;
                exp_rdy  = 1'b0;
                check("reset_rdy", 32'(rx_rdy), 32'(exp_rdy));
                check("reset_data", 32'(rx_data), 32'(exp_data));
                @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (BAUD) @(posedge clk);
                return;
            end
            rx = bits[i / BAUD];
            @(negedge clk);
            if (i >= 4 && rx_rdy === 1'b1) early++;
        end
        @(posedge clk);
        #1 rx = 1'b1;
        check("no_early_rdy", 32'(early), 32'd0);
        if (stop) begin
            exp_data = b;
            exp_rdy  = 1'b1;
        end else begin
            exp_rdy  = 1'b0;
        end
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            if (rx_rdy === 1'b1 && rise_at < 0) rise_at = c;
        end
        check(stop ? "rdy_rose" : "rdy_stayed_low", 32'(rise_at >= 0), 32'(exp_rdy));
        check("data_after_frame", 32'(rx_data), 32'(exp_data));
    endtask

    task automatic glitch(input int len);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (len) @(posedge clk);
        #1 rx = 1'b1;
        repeat (HALF + 10) @(posedge clk);
        @(negedge clk);
        exp_rdy = 1'b0;
        check("glitch_rdy", 32'(rx_rdy), 32'(exp_rdy));
        check("glitch_data", 32'(rx_data), 32'(exp_data));
    endtask

    task automatic idle_gap(input int len);
        repeat (len) @(posedge clk);
        @(negedge clk);
        check("rdy_level_held", 32'(rx_rdy), 32'(exp_rdy));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state_rdy", 32'(rx_rdy), 32'd0);
        check("reset_state_data", 32'(rx_data), 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_gap(20);

        send_frame(8'hA5, 1'b1, -1);
        idle_gap(BAUD);

        send_frame(8'hE7, 1'b1, -1);
        idle_gap(BAUD);
        send_frame(8'h24, 1'b1, -1);
        idle_gap(BAUD);
        send_frame(8'h01, 1'b1, -1);
        idle_gap(BAUD);

        send_frame(8'h5A, 1'b0, -1);
        idle_gap(BAUD);

        glitch(HALF - 10);
        send_frame(8'h3C, 1'b1, -1);
        idle_gap(BAUD);

        send_frame(8'hC3, 1'b1, 5 * BAUD + BAUD / 2);
        send_frame(8'hC3, 1'b1, -1);
        idle_gap(BAUD);

        for (int n = 0; n < 14; n++) begin
            logic [7:0] b;
            logic       s;
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, HALF - 5));
            send_frame(b, s, -1);
            idle_gap($urandom_range(1, BAUD));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
